// File: rtl/ext_int_ctrl_pkg.sv
// ext_int_ctrl_pkg
//   Shared definitions for the external interrupt controller:
//   register word offsets (bus_add[3:2]), FSM state codes, STAT field
//   positions and the vector-number helper.
package ext_int_ctrl_pkg;

  // Register word index, taken from bus_add[3:2]
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // Request FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // STAT register field positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_NUM_LSB  = 8;

  // Vector number of a source: base plus index, wrapping at 8 bits
  function automatic logic [7:0] vector_num(input logic [7:0] base, input logic [4:0] idx);
    return base + {3'b000, idx};
  endfunction

endpackage

// File: rtl/ext_int_ctrl_irq_prio_enc.sv
// irq_prio_enc
//   Fixed-priority encoder: reports the lowest set bit of req.
// Ports
//   req    in   N   request vector, bit 0 has highest priority
//   valid  out  1   at least one request bit set
//   idx    out  5   index of the lowest set bit (0 when valid=0)
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = i[4:0];
      end
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl
//   External interrupt controller feeding the CPU interrupt core.
//   Collects NUM_SRC IRQ lines with per-source edge/level select and mask,
//   picks the lowest eligible index and presents it on
//   int_sign_external / int_num_external until the core acknowledges it.
//   Software sees MASK, PEND, EDGE and STAT on a RAM-style slave bus.
// Ports
//   clk                in   1        system clock, rising edge
//   rst_n              in   1        asynchronous active-low reset
//   irq_in             in   NUM_SRC  device interrupt lines (synchronous)
//   int_sign_external  out  1        request to the interrupt core
//   int_num_external   out  8        vector number, stable while requesting
//   int_ack            in   1        core acceptance (la_ta_ask)
//   bus_add            in   32       register address
//   bus_data_w         in   32       write data
//   bus_data_r         out  32       read data, valid while bus_cplt=1
//   bus_rw             in   2        00 idle, 10 read, 11 write
//   bus_cplt           out  1        access complete
module ext_int_ctrl
  import ext_int_ctrl_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_NUM  = 8'h20,
  parameter logic [31:0] ADDR_BASE = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               int_sign_external,
  output logic [7:0]         int_num_external,
  input  logic               int_ack,
  input  logic [31:0]        bus_add,
  input  logic [31:0]        bus_data_w,
  output logic [31:0]        bus_data_r,
  input  logic [1:0]         bus_rw,
  output logic               bus_cplt
);

  localparam int N = NUM_SRC;

  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] edge_q, edge_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] irq_prev_q;
  logic [1:0]   state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   num_q, num_d;
  logic         sign_q, sign_d;
  logic         cplt_q, cplt_d;
  logic [31:0]  data_r_q, data_r_d;
  logic [1:0]   rw_prev_q;
  logic [31:0]  addr_prev_q;

  logic [N-1:0] rise;
  logic [N-1:0] pend_view;
  logic [N-1:0] eligible;
  logic [N-1:0] w1c;
  logic [31:0]  elig32;
  logic [31:0]  ack_clr32;
  logic [31:0]  rdata;
  logic         hit;
  logic         changed;
  logic         wr_en;
  logic         enc_valid;
  logic [4:0]   enc_idx;
  logic         unused_bits;

  // Pending view: edge bits come from the sticky register, level bits follow irq_in live
  always_comb begin
    rise      = irq_in & ~irq_prev_q;
    pend_view = (pend_q & edge_q) | (irq_in & ~edge_q);
    eligible  = pend_view & mask_q;
    elig32    = '0;
    elig32[N-1:0] = eligible;
  end

  irq_prio_enc #(
    .N(N)
  ) u_prio_enc (
    .req  (eligible),
    .valid(enc_valid),
    .idx  (enc_idx)
  );

  // A new access (rw or address change) drops cplt for one cycle so each access
  // gets its own completion edge; writes commit only on that rising edge.
  always_comb begin
    hit      = (bus_add[31:4] == ADDR_BASE[31:4]);
    changed  = (bus_rw != rw_prev_q) || (bus_add != addr_prev_q);
    cplt_d   = hit & bus_rw[1] & ~(cplt_q & changed);
    wr_en    = cplt_d & ~cplt_q & bus_rw[0];

    rdata = '0;
    case (bus_add[3:2])
      REG_MASK: rdata[N-1:0] = mask_q;
      REG_PEND: rdata[N-1:0] = pend_view;
      REG_EDGE: rdata[N-1:0] = edge_q;
      default: begin
        rdata[STAT_BUSY_BIT]                 = (state_q != ST_IDLE);
        rdata[STAT_NUM_LSB+7:STAT_NUM_LSB]   = num_q;
      end
    endcase
    data_r_d = cplt_d ? rdata : '0;

    mask_d = mask_q;
    edge_d = edge_q;
    w1c    = '0;
    if (wr_en) begin
      case (bus_add[3:2])
        REG_MASK: mask_d = bus_data_w[N-1:0];
        REG_PEND: w1c    = bus_data_w[N-1:0];
        REG_EDGE: edge_d = bus_data_w[N-1:0];
        default:  ;
      endcase
    end
  end

  // Request FSM. Ack is checked before withdraw so it wins; the latched
  // source is never re-arbitrated while in REQ.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    sign_d    = sign_q;
    ack_clr32 = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          idx_d   = enc_idx;
          num_d   = vector_num(BASE_NUM, enc_idx);
          sign_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          sign_d    = 1'b0;
          ack_clr32 = 32'd1 << idx_q;
          state_d   = ST_HOLD;
        end else if (!elig32[idx_q]) begin
          sign_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!int_ack) state_d = ST_IDLE;
      end
      default: begin
        sign_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // New edges win over same-cycle clears; only edge sources keep sticky bits
  always_comb begin
    pend_d = ((pend_q & ~ack_clr32[N-1:0] & ~w1c) | rise) & edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      edge_q      <= '0;
      pend_q      <= '0;
      irq_prev_q  <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      sign_q      <= 1'b0;
      cplt_q      <= 1'b0;
      data_r_q    <= '0;
      rw_prev_q   <= 2'b00;
      addr_prev_q <= '0;
    end else begin
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      pend_q      <= pend_d;
      irq_prev_q  <= irq_in;
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      sign_q      <= sign_d;
      cplt_q      <= cplt_d;
      data_r_q    <= data_r_d;
      rw_prev_q   <= bus_rw;
      addr_prev_q <= bus_add;
    end
  end

  assign int_sign_external = sign_q;
  assign int_num_external  = num_q;
  assign bus_cplt          = cplt_q;
  assign bus_data_r        = data_r_q;

  // Byte offset bits, write-data bits above NUM_SRC and the high part of the
  // one-hot clear vector carry no function
  assign unused_bits = ^{bus_add[1:0], bus_data_w, ack_clr32};

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl
//   Directed testbench for ext_int_ctrl: a vector table for the register
//   interface followed by hand-written sequences for the request FSM.
module tb_ext_int_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_MASK = BASE + 32'h0;
  localparam logic [31:0] A_PEND = BASE + 32'h4;
  localparam logic [31:0] A_EDGE = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_in;
  logic        int_sign_external;
  logic [7:0]  int_num_external;
  logic        int_ack;
  logic [31:0] bus_add;
  logic [31:0] bus_data_w;
  logic [31:0] bus_data_r;
  logic [1:0]  bus_rw;
  logic        bus_cplt;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [7:0]  irq;
    logic [31:0] addr;
    logic [1:0]  rw;
    logic [31:0] wdata;
    logic        exp_cplt;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[20];

  ext_int_ctrl #(
    .NUM_SRC  (8),
    .BASE_NUM (8'h20),
    .ADDR_BASE(32'hFFFF_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_in           (irq_in),
    .int_sign_external(int_sign_external),
    .int_num_external (int_num_external),
    .int_ack          (int_ack),
    .bus_add          (bus_add),
    .bus_data_w       (bus_data_w),
    .bus_data_r       (bus_data_r),
    .bus_rw           (bus_rw),
    .bus_cplt         (bus_cplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic busAccess(input logic [31:0] addr, input logic [1:0] rw, input logic [31:0] wdata,
                           output logic cplt, output logic [31:0] data);
    bus_add    = addr;
    bus_rw     = rw;
    bus_data_w = wdata;
    @(negedge clk);
    cplt = bus_cplt;
    data = bus_data_r;
    bus_rw = 2'b00;
    @(negedge clk);
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic        c;
    logic [31:0] d;
    busAccess(addr, 2'b10, 32'h0, c, d);
    checkOutput({name, "_cplt"}, {31'd0, c}, 32'd1);
    checkOutput(name, d, exp);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata, input string name);
    logic        c;
    logic [31:0] d;
    busAccess(addr, 2'b11, wdata, c, d);
    checkOutput({name, "_cplt"}, {31'd0, c}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic        c;
    logic [31:0] d;
    irq_in = v.irq;
    @(negedge clk);
    busAccess(v.addr, v.rw, v.wdata, c, d);
    checkOutput({v.name, "_cplt"}, {31'd0, c}, {31'd0, v.exp_cplt});
    if (v.chk_data) checkOutput(v.name, d, v.exp_data);
  endtask

  task automatic waitSign(input logic exp, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (int_sign_external == exp) break;
      @(negedge clk);
    end
    checkOutput(name, {31'd0, int_sign_external}, {31'd0, exp});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    irq_in     = 8'h00;
    int_ack    = 1'b0;
    bus_add    = 32'h0;
    bus_data_w = 32'h0;
    bus_rw     = 2'b00;

    vecs[0]  = '{"rd_mask_rst",  8'h00, A_MASK, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[1]  = '{"rd_pend_rst",  8'h00, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[2]  = '{"rd_edge_rst",  8'h00, A_EDGE, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[3]  = '{"rd_stat_rst",  8'h00, A_STAT, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{"wr_edge",      8'h00, A_EDGE, 2'b11, 32'hFFFF_FF0F, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{"rd_edge",      8'h00, A_EDGE, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_000F};
    vecs[6]  = '{"rd_pend_lvl",  8'hF0, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_00F0};
    vecs[7]  = '{"w1c_lvl",      8'hF0, A_PEND, 2'b11, 32'hFF,        1'b1, 1'b0, 32'h0};
    vecs[8]  = '{"rd_pend_lvl2", 8'hF0, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_00F0};
    vecs[9]  = '{"rd_pend_edge", 8'h0F, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_000F};
    vecs[10] = '{"w1c_edge",     8'h0F, A_PEND, 2'b11, 32'h05,        1'b1, 1'b0, 32'h0};
    vecs[11] = '{"rd_pend_w1c",  8'h0F, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_000A};
    vecs[12] = '{"miss_rd",      8'h0F, 32'hFFFF_0010, 2'b10, 32'h0,  1'b0, 1'b1, 32'h0000_0000};
    vecs[13] = '{"miss_wr",      8'h0F, 32'hFFFE_0000, 2'b11, 32'hFF, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{"rd_mask_miss", 8'h0F, A_MASK, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[15] = '{"wr_mask",      8'h00, A_MASK, 2'b11, 32'h1234_56A5, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{"rd_mask",      8'h00, A_MASK, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_00A5};
    vecs[17] = '{"wr_edge0",     8'h00, A_EDGE, 2'b11, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[18] = '{"rd_pend_clr",  8'h00, A_PEND, 2'b10, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[19] = '{"wr_mask0",     8'h00, A_MASK, 2'b11, 32'h0,         1'b1, 1'b0, 32'h0};

    tick(3);
    checkOutput("rst_sign", {31'd0, int_sign_external}, 32'd0);
    checkOutput("rst_num", {24'd0, int_num_external}, 32'd0);
    checkOutput("rst_cplt", {31'd0, bus_cplt}, 32'd0);
    checkOutput("rst_data_r", bus_data_r, 32'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);

    // 1: edge source 2, exact request latency, ack and clear
    busWrite(A_MASK, 32'h04, "t1_wr_mask");
    busWrite(A_EDGE, 32'h04, "t1_wr_edge");
    irq_in = 8'h04;
    @(negedge clk);
    irq_in = 8'h00;
    checkOutput("t1_sign_early", {31'd0, int_sign_external}, 32'd0);
    @(negedge clk);
    checkOutput("t1_sign", {31'd0, int_sign_external}, 32'd1);
    checkOutput("t1_num", {24'd0, int_num_external}, 32'h22);
    tick(3);
    checkOutput("t1_sign_held", {31'd0, int_sign_external}, 32'd1);
    int_ack = 1'b1;
    @(negedge clk);
    checkOutput("t1_sign_ack", {31'd0, int_sign_external}, 32'd0);
    busRead(A_STAT, 32'h0000_2201, "t1_stat_hold");
    busRead(A_PEND, 32'h0, "t1_pend_clr");
    int_ack = 1'b0;
    @(negedge clk);
    busRead(A_STAT, 32'h0000_2200, "t1_stat_idle");

    // 2: level sources 5 and 1 together, lower index first
    busWrite(A_EDGE, 32'h00, "t2_wr_edge");
    busWrite(A_MASK, 32'hFF, "t2_wr_mask");
    irq_in = 8'h22;
    @(negedge clk);
    waitSign(1'b1, 4, "t2_sign1");
    checkOutput("t2_num1", {24'd0, int_num_external}, 32'h21);
    int_ack = 1'b1;
    @(negedge clk);
    checkOutput("t2_sign_ack", {31'd0, int_sign_external}, 32'd0);
    irq_in = 8'h20;
    tick(2);
    checkOutput("t2_no_req_hold", {31'd0, int_sign_external}, 32'd0);
    int_ack = 1'b0;
    @(negedge clk);
    waitSign(1'b1, 4, "t2_sign2");
    checkOutput("t2_num2", {24'd0, int_num_external}, 32'h25);
    int_ack = 1'b1;
    irq_in  = 8'h00;
    @(negedge clk);
    int_ack = 1'b0;
    tick(3);
    checkOutput("t2_quiet", {31'd0, int_sign_external}, 32'd0);

    // 3: withdraw by masking while in REQ
    busWrite(A_MASK, 32'h08, "t3_wr_mask");
    irq_in = 8'h08;
    @(negedge clk);
    waitSign(1'b1, 4, "t3_sign");
    checkOutput("t3_num", {24'd0, int_num_external}, 32'h23);
    busWrite(A_MASK, 32'h00, "t3_wr_mask0");
    checkOutput("t3_withdraw", {31'd0, int_sign_external}, 32'd0);
    busRead(A_STAT, 32'h0000_2300, "t3_stat_idle");
    irq_in = 8'h00;

    // 4: edge on source 0 while in HOLD stays pending and re-requests later
    busWrite(A_EDGE, 32'h01, "t4_wr_edge");
    busWrite(A_MASK, 32'h01, "t4_wr_mask");
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
    waitSign(1'b1, 3, "t4_sign1");
    checkOutput("t4_num1", {24'd0, int_num_external}, 32'h20);
    int_ack = 1'b1;
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
    @(negedge clk);
    busRead(A_PEND, 32'h01, "t4_pend_hold");
    checkOutput("t4_sign_hold", {31'd0, int_sign_external}, 32'd0);
    int_ack = 1'b0;
    @(negedge clk);
    waitSign(1'b1, 4, "t4_sign2");
    checkOutput("t4_num2", {24'd0, int_num_external}, 32'h20);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    @(negedge clk);
    busRead(A_PEND, 32'h00, "t4_pend_clr");

    // 5: STAT read during REQ for source 6, cplt held, W1C on a level bit
    busWrite(A_EDGE, 32'h00, "t5_wr_edge");
    busWrite(A_MASK, 32'h40, "t5_wr_mask");
    irq_in = 8'h40;
    @(negedge clk);
    waitSign(1'b1, 4, "t5_sign");
    bus_add = A_STAT;
    bus_rw  = 2'b10;
    @(negedge clk);
    checkOutput("t5_cplt", {31'd0, bus_cplt}, 32'd1);
    checkOutput("t5_stat", bus_data_r, 32'h0000_2601);
    @(negedge clk);
    checkOutput("t5_cplt_held", {31'd0, bus_cplt}, 32'd1);
    bus_rw = 2'b00;
    @(negedge clk);
    checkOutput("t5_cplt_drop", {31'd0, bus_cplt}, 32'd0);
    busWrite(A_PEND, 32'h40, "t5_w1c");
    busRead(A_PEND, 32'h40, "t5_pend_lvl");
    checkOutput("t5_sign_kept", {31'd0, int_sign_external}, 32'd1);
    int_ack = 1'b1;
    irq_in  = 8'h00;
    @(negedge clk);
    int_ack = 1'b0;
    tick(2);

    // 6: async reset while requesting
    busWrite(A_MASK, 32'h01, "t6_wr_mask");
    irq_in = 8'h01;
    @(negedge clk);
    waitSign(1'b1, 4, "t6_sign");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_sign_rst", {31'd0, int_sign_external}, 32'd0);
    checkOutput("t6_num_rst", {24'd0, int_num_external}, 32'd0);
    irq_in = 8'h08;
    @(posedge clk);
    #1;
    irq_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busRead(A_MASK, 32'h0, "t6_mask");
    busRead(A_PEND, 32'h0, "t6_pend");
    busRead(A_EDGE, 32'h0, "t6_edge");
    busRead(A_STAT, 32'h0, "t6_stat");
    checkOutput("t6_sign_after", {31'd0, int_sign_external}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
